// File: rtl/bb_cmd_engine_if.sv
// Host-side handshake bundle between the FT245 async controller and the
// bit-bang command engine: rx byte 4-phase handshake, tx byte 4-phase
// handshake and the engine status flags (rx_en, busy).
// Ports: slave = engine side, master = FT245 controller / host side.
interface bb_cmd_engine_if;
  logic [7:0] in_rx_data;
  logic       in_rx_hsk_req;
  logic       out_rx_hsk_ack;
  logic       out_rx_en;
  logic [7:0] out_tx_data;
  logic       out_tx_hsk_req;
  logic       in_tx_hsk_ack;
  logic       out_busy;

  modport slave (
    input  in_rx_data, in_rx_hsk_req, in_tx_hsk_ack,
    output out_rx_hsk_ack, out_rx_en, out_tx_data, out_tx_hsk_req, out_busy
  );

  modport master (
    output in_rx_data, in_rx_hsk_req, in_tx_hsk_ack,
    input  out_rx_hsk_ack, out_rx_en, out_tx_data, out_tx_hsk_req, out_busy
  );
endinterface

// File: rtl/bb_cmd_engine.sv
// Purpose : byte-stream bit-bang command engine driving IO_NUM_OF tri-state pads
//           (SET_DIR, SET_OUT, READ_IN, WR_RD; unknown opcode replies 0xFA).
// Latency : READ_IN sample 1 clk after opcode ack, first tx req 1 clk later;
//           payload commit 1 clk after the last payload byte's ack.
// Backpr. : 4-phase rx/tx handshakes; waits indefinitely for payload bytes
//           and tx acks, rx_en low while sampling/settling/replying.
// Ports   : in_clk, in_rst_n (sync, active low), bus (rx/tx handshakes,
//           rx_en, busy), io_pins (bidirectional pads).
module bb_cmd_engine #(
  parameter int IO_NUM_OF     = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  bb_cmd_engine_if.slave       bus,
  inout  wire [IO_NUM_OF-1:0]  io_pins
);

  localparam int NB = (IO_NUM_OF + 7) / 8;
  localparam int PW = NB * 8;
  // The commit clock itself counts as the first settle clock, so the
  // SETTLE state occupies SETTLE_CYCLES-1 clocks and the capture edge lands
  // exactly SETTLE_CYCLES clocks after the commit edge.
  localparam int SETTLE_LOAD = (SETTLE_CYCLES >= 2) ? (SETTLE_CYCLES - 2) : 0;

  localparam logic [7:0] OP_SET_DIR = 8'h01;
  localparam logic [7:0] OP_SET_OUT = 8'h02;
  localparam logic [7:0] OP_READ_IN = 8'h03;
  localparam logic [7:0] OP_WR_RD   = 8'h04;
  localparam logic [7:0] BAD_OP_REPLY = 8'hFA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_PAYLOAD,
    S_SETTLE,
    S_SAMPLE,
    S_SEND,
    S_SEND_WAIT
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [IO_NUM_OF-1:0]   r_dir;
  logic [IO_NUM_OF-1:0]   r_out;
  logic [IO_NUM_OF-1:0]   r_shadow;
  logic [IO_NUM_OF-1:0]   r_sync1;
  logic [IO_NUM_OF-1:0]   r_sync2;   // in_sync
  logic [PW-1:0]          r_reply;
  logic [7:0]             r_op;
  logic [2:0]             r_idx;     // payload byte index, then reply byte index
  logic [2:0]             r_last;    // index of the final reply byte
  logic                   r_full;    // all payload bytes held in shadow
  logic [7:0]             r_cnt;
  logic                   r_rx_ack;
  logic                   r_rx_en;
  logic [7:0]             r_tx_data;
  logic                   r_tx_req;

  logic                   w_rx_take;
  logic                   w_op_take;
  logic                   w_bad_op;
  logic                   w_pay_take;
  logic                   w_commit;
  logic                   w_sample;
  logic                   w_tx_start;
  logic                   w_tx_drop;
  logic                   w_tx_adv;
  logic [7:0]             w_tx_byte;
  logic [PW-1:0]          w_sync_ext;

  // Pads: only direction-enabled bits are driven.
  for (genvar g = 0; g < IO_NUM_OF; g++) begin : g_pad
    assign io_pins[g] = r_dir[g] ? r_out[g] : 1'bz;
  end

  assign w_rx_take = bus.in_rx_hsk_req && !r_rx_ack && r_rx_en;

  // Pad-word bits above IO_NUM_OF read back as zero.
  always_comb begin
    w_sync_ext = '0;
    w_sync_ext[IO_NUM_OF-1:0] = r_sync2;
  end

  always_comb begin
    w_tx_byte = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (r_idx == 3'(b)) w_tx_byte = r_reply[b*8 +: 8];
    end
  end

  // FSM state register
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // FSM next state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_op_take   = 1'b0;
    w_bad_op    = 1'b0;
    w_pay_take  = 1'b0;
    w_commit    = 1'b0;
    w_sample    = 1'b0;
    w_tx_start  = 1'b0;
    w_tx_drop   = 1'b0;
    w_tx_adv    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rx_take) begin
          w_op_take = 1'b1;
          case (bus.in_rx_data)
            OP_SET_DIR, OP_SET_OUT, OP_WR_RD: w_state_nxt = S_GET_PAYLOAD;
            OP_READ_IN:                       w_state_nxt = S_SAMPLE;
            default: begin
              w_bad_op    = 1'b1;
              w_state_nxt = S_SEND;
            end
          endcase
        end
      end
      S_GET_PAYLOAD: begin
        // Commit one clock after the last byte's ack so the pads only ever
        // see complete words.
        if (r_full) begin
          w_commit = 1'b1;
          if (r_op == OP_WR_RD)
            w_state_nxt = (SETTLE_CYCLES >= 2) ? S_SETTLE : S_SAMPLE;
          else
            w_state_nxt = S_IDLE;
        end else if (w_rx_take) begin
          w_pay_take = 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == 8'd0) w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_sample    = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        w_tx_start  = 1'b1;
        w_state_nxt = S_SEND_WAIT;
      end
      S_SEND_WAIT: begin
        if (r_tx_req) begin
          if (bus.in_tx_hsk_ack) w_tx_drop = 1'b1;
        end else if (!bus.in_tx_hsk_ack) begin
          if (r_idx == r_last) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_tx_adv    = 1'b1;
            w_state_nxt = S_SEND;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and handshake registers
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_dir     <= '0;
      r_out     <= '0;
      r_shadow  <= '0;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_reply   <= '0;
      r_op      <= 8'h00;
      r_idx     <= 3'd0;
      r_last    <= 3'd0;
      r_full    <= 1'b0;
      r_cnt     <= 8'd0;
      r_rx_ack  <= 1'b0;
      r_rx_en   <= 1'b0;
      r_tx_data <= 8'h00;
      r_tx_req  <= 1'b0;
    end else begin
      r_sync1 <= io_pins;
      r_sync2 <= r_sync1;

      r_rx_en <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_GET_PAYLOAD);

      if (w_rx_take)               r_rx_ack <= 1'b1;
      else if (!bus.in_rx_hsk_req) r_rx_ack <= 1'b0;

      if (w_op_take) begin
        r_op   <= bus.in_rx_data;
        r_idx  <= 3'd0;
        r_full <= 1'b0;
        r_last <= w_bad_op ? 3'd0 : 3'(NB - 1);
      end

      if (w_bad_op) r_reply <= PW'(BAD_OP_REPLY);

      if (w_pay_take) begin
        for (int i = 0; i < IO_NUM_OF; i++) begin
          if (r_idx == 3'(i / 8)) r_shadow[i] <= bus.in_rx_data[i % 8];
        end
        if (r_idx == 3'(NB - 1)) r_full <= 1'b1;
        else                     r_idx  <= r_idx + 3'd1;
      end

      if (w_commit) begin
        r_full <= 1'b0;
        r_idx  <= 3'd0;
        r_cnt  <= 8'(SETTLE_LOAD);
        if (r_op == OP_SET_DIR) r_dir <= r_shadow;
        else                    r_out <= r_shadow;
      end

      if (r_state == S_SETTLE && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;

      if (w_sample) begin
        r_reply <= w_sync_ext;
        r_idx   <= 3'd0;
      end

      if (w_tx_start) begin
        r_tx_data <= w_tx_byte;
        r_tx_req  <= 1'b1;
      end
      if (w_tx_drop) r_tx_req <= 1'b0;
      if (w_tx_adv)  r_idx    <= r_idx + 3'd1;
    end
  end

  assign bus.out_rx_hsk_ack = r_rx_ack;
  assign bus.out_rx_en      = r_rx_en;
  assign bus.out_tx_data    = r_tx_data;
  assign bus.out_tx_hsk_req = r_tx_req;
  assign bus.out_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_bb_cmd_engine.sv
// Directed bench for bb_cmd_engine (IO_NUM_OF=12, SETTLE_CYCLES=3): drives
// the rx handshake as host, answers tx bytes, and compares each reply byte
// against a queue of expected bytes filled when the command is sent.
module tb_bb_cmd_engine;

  logic        in_clk;
  logic        in_rst_n;
  wire  [11:0] io_pins;
  logic        ext_oe;
  logic [11:0] ext_val;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  bb_cmd_engine_if ifc ();

  bb_cmd_engine #(
    .IO_NUM_OF    (12),
    .SETTLE_CYCLES(3)
  ) dut (
    .in_clk  (in_clk),
    .in_rst_n(in_rst_n),
    .bus     (ifc),
    .io_pins (io_pins)
  );

  assign io_pins = ext_oe ? ext_val : 12'bz;

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    for (int i = 0; i < n; i++) @(negedge in_clk);
  endtask

  // Present a byte and return at the first negedge where ack is seen high
  // (req still asserted).
  task automatic rx_put(input logic [7:0] b);
    int t;
    @(negedge in_clk);
    ifc.in_rx_data    = b;
    ifc.in_rx_hsk_req = 1'b1;
    t = 0;
    while (ifc.out_rx_hsk_ack !== 1'b1 && t < 100) begin
      @(negedge in_clk);
      t++;
    end
    check("rx_ack_rise", ifc.out_rx_hsk_ack, 1);
  endtask

  task automatic rx_release();
    int t;
    ifc.in_rx_hsk_req = 1'b0;
    t = 0;
    while (ifc.out_rx_hsk_ack !== 1'b0 && t < 100) begin
      @(negedge in_clk);
      t++;
    end
    check("rx_ack_fall", ifc.out_rx_hsk_ack, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_put(b);
    rx_release();
  endtask

  // Count negedges until the engine raises tx req.
  task automatic wait_tx_req(output int lat);
    lat = 0;
    while (ifc.out_tx_hsk_req !== 1'b1 && lat < 50) begin
      @(negedge in_clk);
      lat++;
    end
  endtask

  task automatic tx_get(input string tag);
    int t;
    logic [7:0] exp;
    t = 0;
    while (ifc.out_tx_hsk_req !== 1'b1 && t < 100) begin
      @(negedge in_clk);
      t++;
    end
    check("tx_req_rise", ifc.out_tx_hsk_req, 1);
    exp = 8'h00;
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    check(tag, ifc.out_tx_data, exp);
    ifc.in_tx_hsk_ack = 1'b1;
    t = 0;
    while (ifc.out_tx_hsk_req !== 1'b0 && t < 100) begin
      @(negedge in_clk);
      t++;
    end
    check("tx_req_fall", ifc.out_tx_hsk_req, 0);
    ifc.in_tx_hsk_ack = 1'b0;
    @(negedge in_clk);
  endtask

  initial begin
    int lat;
    in_rst_n          = 1'b0;
    ifc.in_rx_data    = 8'h00;
    ifc.in_rx_hsk_req = 1'b0;
    ifc.in_tx_hsk_ack = 1'b0;
    ext_oe            = 1'b0;
    ext_val           = 12'h000;

    // Reset state
    clocks(3);
    check("rst_rx_en",   ifc.out_rx_en, 0);
    check("rst_rx_ack",  ifc.out_rx_hsk_ack, 0);
    check("rst_tx_req",  ifc.out_tx_hsk_req, 0);
    check("rst_tx_data", ifc.out_tx_data, 0);
    check("rst_busy",    ifc.out_busy, 0);
    check("rst_pads_z",  dut.r_dir, 0);
    check("rst_out",     dut.r_out, 0);
    in_rst_n = 1'b1;
    @(negedge in_clk);
    check("rx_en_after_release", ifc.out_rx_en, 1);
    check("idle_busy", ifc.out_busy, 0);
    check("idle_tx_req", ifc.out_tx_hsk_req, 0);

    // SET_DIR all pads, then SET_OUT 0x234 committed atomically
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'h0F);
    check("dir_commit", dut.r_dir, 12'hFFF);
    check("pads_zero", io_pins, 12'h000);
    send_byte(8'h02); send_byte(8'h34);
    check("pads_no_partial", io_pins, 12'h000);
    check("busy_mid_payload", ifc.out_busy, 1);
    rx_put(8'h12);
    check("pads_before_commit", io_pins, 12'h000);
    ifc.in_rx_hsk_req = 1'b0;
    @(negedge in_clk);
    check("pads_commit_1clk", io_pins, 12'h234);
    rx_release();

    // Release pads, drive them externally, READ_IN
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    check("dir_cleared", dut.r_dir, 12'h000);
    ext_val = 12'hA5C;
    ext_oe  = 1'b1;
    clocks(4);
    exp_q.push_back(8'h5C);
    exp_q.push_back(8'h0A);
    rx_put(8'h03);
    ifc.in_rx_hsk_req = 1'b0;
    wait_tx_req(lat);
    check("read_in_req_latency", lat, 2);
    tx_get("read_in_b0");
    tx_get("read_in_b1");
    ext_oe = 1'b0;

    // WR_RD with pads looped back through the engine's own drivers
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'h0F);
    send_byte(8'h04); send_byte(8'h0F);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h00);
    rx_put(8'h00);
    ifc.in_rx_hsk_req = 1'b0;
    wait_tx_req(lat);
    // commit +1, sample 3 clks after commit, req 1 clk after sample
    check("wr_rd_req_latency", lat, 5);
    check("wr_rd_pads", io_pins, 12'h00F);
    tx_get("wr_rd_b0");
    tx_get("wr_rd_b1");

    // Unknown opcode -> single 0xFA, then normal decode resumes
    exp_q.push_back(8'hFA);
    send_byte(8'h7E);
    tx_get("bad_op_reply");
    clocks(3);
    check("bad_op_no_extra_req", ifc.out_tx_hsk_req, 0);
    check("bad_op_idle", ifc.out_busy, 0);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h00);
    send_byte(8'h03);
    tx_get("after_bad_b0");
    tx_get("after_bad_b1");

    // Reset in the middle of a SET_OUT payload
    send_byte(8'h02); send_byte(8'h34);
    in_rst_n = 1'b0;
    clocks(2);
    check("midrst_pads_z", dut.r_dir, 0);
    check("midrst_out", dut.r_out, 0);
    check("midrst_busy", ifc.out_busy, 0);
    check("midrst_rx_en", ifc.out_rx_en, 0);
    in_rst_n = 1'b1;
    ext_val  = 12'h123;
    ext_oe   = 1'b1;
    clocks(4);
    exp_q.push_back(8'h23);
    exp_q.push_back(8'h01);
    send_byte(8'h03);
    tx_get("post_rst_b0");
    tx_get("post_rst_b1");
    clocks(2);
    check("final_idle", ifc.out_busy, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
